// File: rtl/leaf_stream_tx_pkg.sv
// Shared definitions for the leaf stream transmitter.
// Holds the BFT packet field layout, the control opcodes, the credit ceiling,
// the FSM state encodings and the saturating credit update helper.
package leaf_stream_tx_pkg;

  // Packet layout, MSB to LSB: valid | leaf | port | addr | ctrl | payload
  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB  = 44;
  localparam int PORT_LSB  = 40;
  localparam int ADDR_LSB  = 33;
  localparam int CTRL_BIT  = 32;
  localparam int OP_LSB    = 30;

  localparam logic [1:0] OP_CONFIG = 2'b01;
  localparam logic [1:0] OP_UPDATE = 2'b10;

  // Remote receive BRAM depth; this is also the reset/CONFIG credit value.
  localparam logic [8:0] CREDIT_MAX = 9'd128;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Credit after one cycle: optional increment, optional consumed word.
  // Evaluated in 9 bits so credit + increment cannot wrap before saturation.
  // A word is only taken when credit is nonzero, so the subtraction cannot underflow.
  function automatic logic [7:0] credit_next(input logic [7:0] cur,
                                             input logic [7:0] inc,
                                             input logic       add,
                                             input logic       take);
    logic [8:0] sum;
    sum = {1'b0, cur} + (add ? {1'b0, inc} : 9'd0) - {8'd0, take};
    if (sum > CREDIT_MAX) begin
      credit_next = CREDIT_MAX[7:0];
    end else begin
      credit_next = sum[7:0];
    end
  endfunction

endpackage

// File: rtl/leaf_stream_tx_ctrl_decode.sv
// leaf_ctrl_decode: combinational classifier for downlink BFT packets.
// Ports:
//   pkt_i         downlink packet
//   is_config_o   valid control packet carrying the CONFIG opcode
//   is_update_o   valid control packet carrying the UPDATE opcode
//   cfg_leaf_o    destination leaf carried by CONFIG
//   cfg_port_o    destination port carried by CONFIG
//   credit_inc_o  free-space increment carried by UPDATE
module leaf_ctrl_decode
  import leaf_stream_tx_pkg::*;
#(
  parameter int PACKET_BITS   = 49,
  parameter int NUM_LEAF_BITS = 4,
  parameter int NUM_PORT_BITS = 4
) (
  input  logic [PACKET_BITS-1:0]   pkt_i,
  output logic                     is_config_o,
  output logic                     is_update_o,
  output logic [NUM_LEAF_BITS-1:0] cfg_leaf_o,
  output logic [NUM_PORT_BITS-1:0] cfg_port_o,
  output logic [7:0]               credit_inc_o
);

  logic       is_ctrl;
  logic [1:0] opcode;
  logic       unused_bits;

  // Data packets (ctrl=0) and idle slots (valid=0) are never control.
  assign is_ctrl = pkt_i[VALID_BIT] & pkt_i[CTRL_BIT];
  assign opcode  = pkt_i[OP_LSB +: 2];

  assign is_config_o  = is_ctrl & (opcode == OP_CONFIG);
  assign is_update_o  = is_ctrl & (opcode == OP_UPDATE);
  assign cfg_leaf_o   = pkt_i[NUM_PORT_BITS +: NUM_LEAF_BITS];
  assign cfg_port_o   = pkt_i[0 +: NUM_PORT_BITS];
  assign credit_inc_o = pkt_i[7:0];

  assign unused_bits = ^{pkt_i[CTRL_BIT-1 +: 1], pkt_i[VALID_BIT-1:CTRL_BIT+1],
                         pkt_i[OP_LSB-1:8]};

endmodule

// File: rtl/leaf_stream_tx.sv
// leaf_stream_tx: credit-based transmitter from a user valid/ack stream to BFT
// packets addressed to one remote leaf input port.
// Ports:
//   clk                      sole clock
//   reset                    synchronous, active-high
//   din_leaf_bft2interface   downlink packets (CONFIG/UPDATE control consumed)
//   dout_leaf_interface2bft  uplink packets, registered, one cycle after ack
//   din_leaf_user2interface  user data word
//   vld_user2interface       user word valid
//   ack_interface2user       word accepted this cycle (combinational)
//   cfg_done                 destination has been configured
//   credit                   current remote free-space count
module leaf_stream_tx
  import leaf_stream_tx_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  output logic                     cfg_done,
  output logic [7:0]               credit
);

  localparam int unused_freespace_update_size = FREESPACE_UPDATE_SIZE;

  logic                     is_config;
  logic                     is_update;
  logic [NUM_LEAF_BITS-1:0] cfg_leaf;
  logic [NUM_PORT_BITS-1:0] cfg_port;
  logic [7:0]               credit_inc;

  logic                     state_q,    state_d;
  logic [7:0]               credit_q,   credit_d;
  logic [NUM_ADDR_BITS-1:0] addr_q,     addr_d;
  logic [NUM_LEAF_BITS-1:0] dst_leaf_q, dst_leaf_d;
  logic [NUM_PORT_BITS-1:0] dst_port_q, dst_port_d;
  logic [PACKET_BITS-1:0]   dout_q,     dout_d;
  logic                     xfer;

  leaf_ctrl_decode #(
    .PACKET_BITS   (PACKET_BITS),
    .NUM_LEAF_BITS (NUM_LEAF_BITS),
    .NUM_PORT_BITS (NUM_PORT_BITS)
  ) u_decode (
    .pkt_i        (din_leaf_bft2interface),
    .is_config_o  (is_config),
    .is_update_o  (is_update),
    .cfg_leaf_o   (cfg_leaf),
    .cfg_port_o   (cfg_port),
    .credit_inc_o (credit_inc)
  );

  // Holding ack low while reset is high keeps a word from being consumed
  // in a cycle whose packet would be discarded anyway.
  assign ack_interface2user = (state_q == ST_RUN) & (credit_q != 8'd0) &
                              vld_user2interface & ~reset;
  assign xfer = vld_user2interface & ack_interface2user;

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_next(credit_q, credit_inc, is_update, xfer);
    addr_d     = xfer ? addr_q + NUM_ADDR_BITS'(1) : addr_q;
    dst_leaf_d = dst_leaf_q;
    dst_port_d = dst_port_q;
    dout_d     = '0;

    // The outgoing packet always uses the pre-CONFIG destination and address.
    if (xfer) begin
      dout_d = {1'b1, dst_leaf_q, dst_port_q, addr_q, 1'b0, din_leaf_user2interface};
    end

    // CONFIG overrides any same-cycle credit/address change.
    if (is_config) begin
      state_d    = ST_RUN;
      credit_d   = CREDIT_MAX[7:0];
      addr_d     = '0;
      dst_leaf_d = cfg_leaf;
      dst_port_d = cfg_port;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      credit_q   <= CREDIT_MAX[7:0];
      addr_q     <= '0;
      dst_leaf_q <= '0;
      dst_port_q <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      addr_q     <= addr_d;
      dst_leaf_q <= dst_leaf_d;
      dst_port_q <= dst_port_d;
      dout_q     <= dout_d;
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign cfg_done                = state_q;
  assign credit                  = credit_q;

endmodule

// File: tb/tb_leaf_stream_tx.sv
// Directed bench for leaf_stream_tx.
module tb_leaf_stream_tx;

  logic        clk;
  logic        reset;
  logic [48:0] bft_in;
  logic [48:0] bft_out;
  logic [31:0] din;
  logic        vld;
  logic        ack;
  logic        cfg_done;
  logic [7:0]  credit;

  int checks = 0;
  int passes = 0;

  leaf_stream_tx dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_bft2interface  (bft_in),
    .dout_leaf_interface2bft (bft_out),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_done                (cfg_done),
    .credit                  (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] mkctrl(input logic [31:0] payload);
    mkctrl = {1'b1, 4'h0, 4'h0, 7'h00, 1'b1, payload};
  endfunction

  function automatic logic [48:0] mkdata(input logic [3:0] leaf, input logic [3:0] port,
                                         input logic [6:0] addr, input logic [31:0] word);
    mkdata = {1'b1, leaf, port, addr, 1'b0, word};
  endfunction

  task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    bft_in = '0;
    din    = '0;
    vld    = 1'b0;
    tick();
    tick();
    chk("rst_dout",   bft_out,  49'd0);
    chk("rst_ack",    49'(ack), 49'd0);
    chk("rst_cfg",    49'(cfg_done), 49'd0);
    chk("rst_credit", 49'(credit), 49'd128);

    // Unconfigured: word presented but never accepted.
    reset = 1'b0;
    vld   = 1'b1;
    din   = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_ack", 49'(ack), 49'd0);
      tick();
      chk("idle_dout", bft_out, 49'd0);
    end

    // CONFIG to leaf 3, port 5.
    vld    = 1'b0;
    bft_in = mkctrl(32'h4000_0035);
    tick();
    bft_in = '0;
    chk("cfg_done", 49'(cfg_done), 49'd1);
    chk("cfg_credit", 49'(credit), 49'd128);

    for (int i = 0; i < 3; i++) begin
      vld = 1'b1;
      din = 32'(i + 1);
      #1;
      chk("w3_ack", 49'(ack), 49'd1);
      tick();
      chk("w3_dout", bft_out, mkdata(4'h3, 4'h5, 7'(i), 32'(i + 1)));
    end
    vld = 1'b0;
    tick();
    chk("w3_idle_dout", bft_out, 49'd0);
    chk("w3_credit", 49'(credit), 49'd125);

    // Re-CONFIG while running restores full credit and addr 0.
    bft_in = mkctrl(32'h4000_0035);
    tick();
    bft_in = '0;
    chk("recfg_credit", 49'(credit), 49'd128);
    chk("recfg_cfg", 49'(cfg_done), 49'd1);

    // Drain all 128 credits; addr runs 0..127.
    vld = 1'b1;
    for (int i = 0; i < 128; i++) begin
      din = 32'h0500_0000 + 32'(i);
      #1;
      chk("s128_ack", 49'(ack), 49'd1);
      tick();
      chk("s128_dout", bft_out, mkdata(4'h3, 4'h5, 7'(i), 32'h0500_0000 + 32'(i)));
    end
    #1;
    chk("empty_ack", 49'(ack), 49'd0);
    chk("empty_credit", 49'(credit), 49'd0);
    tick();
    chk("empty_dout", bft_out, 49'd0);

    // UPDATE +64 while the word is pending.
    bft_in = mkctrl(32'h8000_0040);
    tick();
    bft_in = '0;
    chk("upd_credit", 49'(credit), 49'd64);
    for (int i = 0; i < 64; i++) begin
      din = 32'h0600_0000 + 32'(i);
      #1;
      chk("s64_ack", 49'(ack), 49'd1);
      tick();
      chk("s64_dout", bft_out, mkdata(4'h3, 4'h5, 7'(i), 32'h0600_0000 + 32'(i)));
    end
    #1;
    chk("s64_empty_ack", 49'(ack), 49'd0);

    // Bring credit to 100.
    vld    = 1'b0;
    bft_in = mkctrl(32'h8000_0064);
    tick();
    bft_in = '0;
    chk("c100_credit", 49'(credit), 49'd100);
    chk("c100_dout", bft_out, 49'd0);

    // UPDATE +64 with a transfer at credit 100 saturates at 128.
    vld    = 1'b1;
    din    = 32'h2222_0000;
    bft_in = mkctrl(32'h8000_0040);
    #1;
    chk("sat_ack", 49'(ack), 49'd1);
    tick();
    bft_in = '0;
    vld    = 1'b0;
    chk("sat_credit", 49'(credit), 49'd128);
    chk("sat_dout", bft_out, mkdata(4'h3, 4'h5, 7'd64, 32'h2222_0000));

    // 118 transfers leave credit at 10 and addr at 55.
    vld = 1'b1;
    din = 32'h3333_0000;
    repeat (118) tick();
    vld = 1'b0;
    tick();
    chk("c10_credit", 49'(credit), 49'd10);
    bft_in = mkctrl(32'h8000_0040);
    tick();
    bft_in = '0;
    chk("c74_credit", 49'(credit), 49'd74);

    // CONFIG to leaf A, port 7 alongside a transfer.
    vld    = 1'b1;
    din    = 32'hAAAA_0001;
    bft_in = mkctrl(32'h4000_00A7);
    tick();
    bft_in = '0;
    chk("cfgx_dout", bft_out, mkdata(4'h3, 4'h5, 7'd55, 32'hAAAA_0001));
    chk("cfgx_credit", 49'(credit), 49'd128);
    din = 32'hBBBB_0002;
    tick();
    chk("cfgx_next_dout", bft_out, mkdata(4'hA, 4'h7, 7'd0, 32'hBBBB_0002));
    chk("cfgx_next_credit", 49'(credit), 49'd127);

    // One-cycle reset mid-stream.
    din   = 32'hCCCC_0003;
    reset = 1'b1;
    #1;
    chk("mrst_ack_during", 49'(ack), 49'd0);
    tick();
    reset = 1'b0;
    chk("mrst_dout", bft_out, 49'd0);
    chk("mrst_cfg", 49'(cfg_done), 49'd0);
    chk("mrst_credit", 49'(credit), 49'd128);
    #1;
    chk("mrst_ack", 49'(ack), 49'd0);
    tick();
    chk("mrst_dout2", bft_out, 49'd0);
    #1;
    chk("mrst_ack2", 49'(ack), 49'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/leaf_stream_tx.md
Name: leaf_stream_tx

Overview:
- Credit-based transmitter that packs a user-side 32-bit valid/ack stream into BFT packets addressed to one remote leaf input port.
- Sits between an HLS operator's output stream (Output_x_V_*) and the leaf's BFT uplink.
- Destination and credit replenishment come from control packets on the BFT downlink.
- Does not overrun the remote port's receive BRAM.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 4, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, remote BRAM write-address field width.
- FREESPACE_UPDATE_SIZE, 64, credit granularity (informational; the increment is carried in the packet).

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- din_leaf_bft2interface  in  49  downlink packets (control only consumed here).
- dout_leaf_interface2bft  out  49  uplink packets.
- din_leaf_user2interface  in  32  user data word.
- vld_user2interface  in  1  user word valid.
- ack_interface2user  out  1  word accepted this cycle.
- cfg_done  out  1  destination configured.
- credit  out  8  current remote free-space count, for debug.

Behaviour:
- Packet format, MSB to LSB:
  - [48] valid
  - [47:44] leaf
  - [43:40] port
  - [39:33] addr
  - [32] ctrl
  - [31:0] payload
- Reset values:
  - dout = 0
  - ack = 0
  - cfg_done = 0
  - credit = 128 (2^NUM_ADDR_BITS)
  - addr counter = 0
  - dst leaf/port = 0
- Control decode: a downlink packet with valid=1 and ctrl=1 is control. Data packets (ctrl=0) are ignored.
  - payload[31:30]=01 is CONFIG: dst_leaf=payload[7:4], dst_port=payload[3:0], cfg_done<=1. It resets credit to 128 and addr to 0.
  - payload[31:30]=10 is UPDATE: credit += payload[7:0]. The result saturates at 128.
  - Other opcodes are ignored.
- ack_interface2user is combinational: cfg_done & (credit!=0) & vld_user2interface & ~reset.
- Transfer fires when vld & ack. On the next cycle dout carries:
  - valid=1, dst_leaf, dst_port
  - addr = current addr counter
  - ctrl=0, payload = the word
- Latency is exactly 1 cycle, with at most one packet per cycle.
- When no transfer fires, dout valid=0 and the remaining dout bits are 0.
- The uplink has no backpressure; credit alone guarantees space.
- addr increments mod 128 per transfer (127 wraps to 0).
- Credit rules:
  - Transfer only: credit-1.
  - Update only: credit+inc, saturated.
  - Same cycle: credit-1+inc, saturated at 128, computed in 9-bit arithmetic.
- CONFIG in the same cycle as a transfer: the transfer completes with the old dst/addr. CONFIG wins the credit/addr update (credit=128, addr=0).
- credit==0 holds ack=0. A word with vld held stays pending; user data must remain stable (HLS AXIS semantics).
- Reset mid-stream drops any in-flight output. dout returns to 0 on the cycle after reset is sampled, and cfg_done must be re-established.
- Internal state: IDLE (unconfigured) -> RUN on CONFIG. RUN stays RUN on further CONFIG. Reset is the only exit to IDLE.

Decomposition:
- Shared package holds:
  - field offsets/widths for the 49-bit packet (VALID_BIT, LEAF_LSB, PORT_LSB, ADDR_LSB, CTRL_BIT)
  - opcode constants OP_CONFIG=2'b01, OP_UPDATE=2'b10
  - CREDIT_MAX=128
- One natural sub-module: leaf_ctrl_decode. It is combinational: from the downlink packet it produces is_config, is_update, cfg_leaf, cfg_port, credit_inc.
- Counters and the output register stay in leaf_stream_tx.

Test Plan:
- Unconfigured, vld=1 with word 0xDEADBEEF for 10 cycles -> ack=0 throughout, dout valid=0.
- CONFIG payload 0x4000_0035, then 3 words 0x1,0x2,0x3 -> dout = {1,4'h3,4'h5,addr 0/1/2,0,word} each one cycle after ack. Credit ends at 125.
- Stream 128 words with no UPDATE -> 128 acks, addr wraps 127->0 on the last, then ack=0 with credit=0. UPDATE inc=64 -> ack resumes next cycle, 64 more words accepted.
- UPDATE inc=64 arriving the same cycle as a transfer at credit=100 -> credit=128 (saturated, not 163). UPDATE with credit=10 and no transfer -> 74.
- CONFIG arriving mid-stream with a simultaneous transfer -> that packet uses the old dst and addr. The next packet uses the new dst with addr=0, and credit=127 after it.
- Assert reset for 1 cycle mid-stream -> dout=0, ack=0, cfg_done=0 and credit=128 the following cycle. No ack until a new CONFIG.
